file_register: RTL and testbench
================================

Name: file_register

Overview:
Command/status register bank between a soft microcontroller's GPIO pair and the convolution datapath.
- Decodes 32-bit instructions on gpi0 (i_cmd_from_micro).
- Drives kernel select, frame-load and start-convolution controls.
- Returns status and frame data to the micro on gpo0 (o_data_to_micro).
- Each command executes once per rising edge of the instruction's enable bit.

Parameters:
NB_C0M, 8, command field width
NB_DATA, 24, enable bit plus data field width
NB_INST, 32, instruction / GPIO word width (= NB_C0M + NB_DATA)

Ports:
clock  in  1  system clock, rising-edge active
reset  in  1  asynchronous, active-low reset (asserted when 0)
i_cmd_from_micro  in  NB_INST  instruction from micro (gpi0)
i_frame_ready  in  1  processed frame available in memory
i_frame_from_mem  in  NB_INST  frame word read from memory
o_data_to_micro  out  NB_INST  response word to micro (gpo0)
o_frame_from_micro  out  NB_DATA  frame word to be written to memory
o_kernel_sel  out  2  convolution kernel select
o_load  out  1  one-cycle write strobe for o_frame_from_micro
o_start_conv  out  1  one-cycle start-convolution strobe

Behaviour:
Instruction fields:
- cmd = [NB_INST-1 : NB_DATA]
- enable = [NB_DATA-1]
- data = [NB_DATA-2 : 0] (23 bits)

Opcodes:
- KERNEL_SEL = 0
- LOAD_FRAME = 1
- END_FRAME = 2
- IS_FRAME_READY = 3
- GET_FRAME = 4
- Any other opcode: no action, all registers hold.

Enable edge detection:
- An enable_d register samples enable every clock.
- A command executes on the clock edge where enable = 1 and enable_d = 0.
- Executed effects are visible after that edge (one-cycle latency from enable sampled high).
- Holding enable high does not re-execute the command; enable must return to 0 first.

Command effects:
- KERNEL_SEL: o_kernel_sel <= data[1:0]; held until the next KERNEL_SEL.
- LOAD_FRAME: o_frame_from_micro <= {1'b0, data}; o_load = 1 for exactly one cycle.
- END_FRAME: o_start_conv = 1 for exactly one cycle.
- IS_FRAME_READY: o_data_to_micro <= {31'b0, i_frame_ready}, sampled at the execute edge.
- GET_FRAME: o_data_to_micro <= i_frame_from_mem, sampled at the execute edge.

General rules:
- o_load and o_start_conv are 0 in every cycle other than the one following their execute edge.
- o_data_to_micro, o_frame_from_micro and o_kernel_sel hold their value between commands.
- Changes to cmd/data while enable stays high are ignored.
- cmd/data are sampled only on the execute edge.
- All outputs are registered; no combinational input-to-output path.

Reset (reset = 0, asynchronous):
- All outputs and enable_d = 0 (o_kernel_sel = 2'b00).
- Reset mid-command aborts any pending strobe.
- Enable already high when reset releases: it is treated as a new rising edge only if enable_d was 0 at the first clock after release. Because reset clears enable_d, the command executes once after release.

Decomposition:
- Shared package holds the opcode localparams (KERNEL_SEL, LOAD_FRAME, END_FRAME, IS_FRAME_READY, GET_FRAME) and field-position constants derived from NB_INST/NB_C0M/NB_DATA.
- One natural sub-module: rise_edge_detect (1-bit register plus AND-NOT, async active-low reset), producing the execute pulse.
- Decoder and output registers stay in file_register.

Test Plan:
1. Reset:
   - Stimulus: hold reset = 0 with arbitrary inputs.
   - Response: all outputs 0. After release with enable = 0, outputs stay 0.
2. Kernel select:
   - Stimulus: 0x00000003, then 0x00800003, then 0x00000003.
   - Response: o_kernel_sel = 3 one cycle after enable rises; the value persists after enable drops.
   - Stimulus: repeat with data = 2.
   - Response: o_kernel_sel = 2.
3. Frame ready status:
   - Stimulus: i_frame_ready = 1, then 0x03000000, 0x03800000, 0x03000000.
   - Response: o_data_to_micro = 0x00000001.
   - Stimulus: repeat with i_frame_ready = 0.
   - Response: o_data_to_micro = 0x00000000.
4. Load and end frame:
   - Stimulus: 0x01800ABC pulsed.
   - Response: o_frame_from_micro = 0x000ABC with o_load = 1 for exactly one cycle.
   - Stimulus: 0x02800000 pulsed.
   - Response: o_start_conv = 1 for exactly one cycle.
   - Stimulus: hold enable high 5 cycles.
   - Response: still a single strobe.
5. Get frame:
   - Stimulus: i_frame_from_mem = 0xDEADBEEF, then 0x04800000 pulsed.
   - Response: o_data_to_micro = 0xDEADBEEF.
   - Stimulus: change i_frame_from_mem afterwards without a new edge.
   - Response: o_data_to_micro unchanged.
6. Robustness:
   - Stimulus: opcode 0x07 with enable edge.
   - Response: no output changes.
   - Stimulus: reset asserted in the strobe cycle of LOAD_FRAME.
   - Response: o_load and o_frame_from_micro forced to 0 immediately.

Source files
------------

// File: rtl/file_register_pkg.sv
// file_register_pkg: opcodes and default field widths shared by the micro command register bank.
package file_register_pkg;
    localparam int DEF_NB_C0M  = 8;
    localparam int DEF_NB_DATA = 24;
    localparam int DEF_NB_INST = DEF_NB_C0M + DEF_NB_DATA;
    typedef logic [DEF_NB_C0M-1:0] opcode_t;
    localparam opcode_t KERNEL_SEL     = 8'd0;
    localparam opcode_t LOAD_FRAME     = 8'd1;
    localparam opcode_t END_FRAME      = 8'd2;
    localparam opcode_t IS_FRAME_READY = 8'd3;
    localparam opcode_t GET_FRAME      = 8'd4;
endpackage

// File: rtl/rise_edge_detect.sv
// rise_edge_detect: one-cycle pulse while sig_i is high and was low on the previous clock.
module rise_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic rise_o
);
    logic sig_q;
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) sig_q <= 1'b0;
        else         sig_q <= sig_i;
    assign rise_o = sig_i & ~sig_q;
endmodule

// File: rtl/file_register.sv
// file_register: decodes micro GPIO instructions into kernel/frame controls and status replies.
module file_register
    import file_register_pkg::*;
#(
    parameter int NB_C0M  = DEF_NB_C0M,
    parameter int NB_DATA = DEF_NB_DATA,
    parameter int NB_INST = NB_C0M + NB_DATA
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NB_INST-1:0] i_cmd_from_micro,
    input  logic               i_frame_ready,
    input  logic [NB_INST-1:0] i_frame_from_mem,
    output logic [NB_INST-1:0] o_data_to_micro,
    output logic [NB_DATA-1:0] o_frame_from_micro,
    output logic [1:0]         o_kernel_sel,
    output logic               o_load,
    output logic               o_start_conv
);
    logic [NB_C0M-1:0]  cmd;
    logic [NB_DATA-2:0] data;
    logic               exec;
    logic [NB_INST-1:0] data_q, data_d;
    logic [NB_DATA-1:0] frame_q, frame_d;
    logic [1:0]         kernel_q, kernel_d;
    logic               load_q, load_d, start_q, start_d;
    assign cmd  = i_cmd_from_micro[NB_INST-1:NB_DATA];
    assign data = i_cmd_from_micro[NB_DATA-2:0];
    rise_edge_detect u_en_edge (
        .clk_i  (clock),
        .rst_ni (reset),
        .sig_i  (i_cmd_from_micro[NB_DATA-1]),
        .rise_o (exec)
    );
    always_comb begin
        data_d   = data_q;
        frame_d  = frame_q;
        kernel_d = kernel_q;
        load_d   = 1'b0;
        start_d  = 1'b0;
        if (exec)
            case (cmd)
                KERNEL_SEL:     kernel_d = data[1:0];
                LOAD_FRAME:     begin frame_d = {1'b0, data}; load_d = 1'b1; end
                END_FRAME:      start_d = 1'b1;
                IS_FRAME_READY: data_d = {{(NB_INST-1){1'b0}}, i_frame_ready};
                GET_FRAME:      data_d = i_frame_from_mem;
                default:        ;
            endcase
    end
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            data_q   <= '0;
            frame_q  <= '0;
            kernel_q <= '0;
            load_q   <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            data_q   <= data_d;
            frame_q  <= frame_d;
            kernel_q <= kernel_d;
            load_q   <= load_d;
            start_q  <= start_d;
        end
    assign o_data_to_micro    = data_q;
    assign o_frame_from_micro = frame_q;
    assign o_kernel_sel       = kernel_q;
    assign o_load             = load_q;
    assign o_start_conv       = start_q;
endmodule

// File: tb/tb_file_register.sv
// tb_file_register: table-driven command vectors through a scoreboard queue plus multi-cycle corner cases.
module tb_file_register;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] i_cmd_from_micro = '0;
    logic        i_frame_ready = 1'b0;
    logic [31:0] i_frame_from_mem = '0;
    logic [31:0] o_data_to_micro;
    logic [23:0] o_frame_from_micro;
    logic [1:0]  o_kernel_sel;
    logic        o_load;
    logic        o_start_conv;
    int n_chk = 0;
    int n_fail = 0;
    localparam logic [31:0] EN = 32'h0080_0000;
    typedef struct {
        logic [31:0] cmd;
        logic        ready;
        logic [31:0] mem;
        logic [1:0]  kernel;
        logic [23:0] frame;
        logic [31:0] data;
        logic        load;
        logic        start;
    } vec_t;
    vec_t tbl[10];
    vec_t sb[$];
    file_register dut (
        .clock              (clock),
        .reset              (reset),
        .i_cmd_from_micro   (i_cmd_from_micro),
        .i_frame_ready      (i_frame_ready),
        .i_frame_from_mem   (i_frame_from_mem),
        .o_data_to_micro    (o_data_to_micro),
        .o_frame_from_micro (o_frame_from_micro),
        .o_kernel_sel       (o_kernel_sel),
        .o_load             (o_load),
        .o_start_conv       (o_start_conv)
    );
    always #5 clock = ~clock;
    task automatic step();
        @(posedge clock);
        #1;
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask
    task automatic chk_all(input string tag, input vec_t e, input logic load, input logic start);
        chk({tag, " kernel"}, 32'(o_kernel_sel), 32'(e.kernel));
        chk({tag, " frame"}, 32'(o_frame_from_micro), 32'(e.frame));
        chk({tag, " data"}, o_data_to_micro, e.data);
        chk({tag, " load"}, 32'(o_load), 32'(load));
        chk({tag, " start"}, 32'(o_start_conv), 32'(start));
    endtask
    initial begin
        vec_t e;
        vec_t z;
        int n_start, n_load;
        tbl[0] = '{32'h0000_0003, 1'b0, 32'h0,         2'd3, 24'h0,      32'h0,         1'b0, 1'b0};
        tbl[1] = '{32'h0000_0002, 1'b0, 32'h0,         2'd2, 24'h0,      32'h0,         1'b0, 1'b0};
        tbl[2] = '{32'h0300_0000, 1'b1, 32'h0,         2'd2, 24'h0,      32'h1,         1'b0, 1'b0};
        tbl[3] = '{32'h0300_0000, 1'b0, 32'h0,         2'd2, 24'h0,      32'h0,         1'b0, 1'b0};
        tbl[4] = '{32'h0100_0ABC, 1'b1, 32'h1234_5678, 2'd2, 24'h000ABC, 32'h0,         1'b1, 1'b0};
        tbl[5] = '{32'h0200_0000, 1'b1, 32'h1234_5678, 2'd2, 24'h000ABC, 32'h0,         1'b0, 1'b1};
        tbl[6] = '{32'h0400_0000, 1'b1, 32'hDEAD_BEEF, 2'd2, 24'h000ABC, 32'hDEAD_BEEF, 1'b0, 1'b0};
        tbl[7] = '{32'h0712_3456, 1'b1, 32'h5555_AAAA, 2'd2, 24'h000ABC, 32'hDEAD_BEEF, 1'b0, 1'b0};
        tbl[8] = '{32'h017F_FFFF, 1'b0, 32'h0,         2'd2, 24'h7FFFFF, 32'hDEAD_BEEF, 1'b1, 1'b0};
        tbl[9] = '{32'h007F_FFFD, 1'b0, 32'h0,         2'd1, 24'h7FFFFF, 32'hDEAD_BEEF, 1'b0, 1'b0};
        z = '{32'h0, 1'b0, 32'h0, 2'd0, 24'h0, 32'h0, 1'b0, 1'b0};
        i_cmd_from_micro = 32'hFF80_FFFF;
        i_frame_ready    = 1'b1;
        i_frame_from_mem = 32'hCAFE_F00D;
        repeat (3) step();
        chk_all("reset", z, 1'b0, 1'b0);
        i_cmd_from_micro = 32'h0100_0123;
        reset = 1'b1;
        repeat (2) step();
        chk_all("post_reset idle", z, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            i_frame_ready    = tbl[i].ready;
            i_frame_from_mem = tbl[i].mem;
            i_cmd_from_micro = tbl[i].cmd | EN;
            sb.push_back(tbl[i]);
            step();
            e = sb.pop_front();
            chk_all($sformatf("vec%0d exec", i), e, e.load, e.start);
            i_cmd_from_micro = tbl[i].cmd & ~EN;
            step();
            chk_all($sformatf("vec%0d hold", i), e, 1'b0, 1'b0);
        end
        i_frame_from_mem = 32'h0BAD_F00D;
        i_frame_ready    = 1'b1;
        repeat (2) step();
        chk("get_frame no re-sample", o_data_to_micro, 32'hDEAD_BEEF);
        n_start = 0;
        n_load  = 0;
        i_cmd_from_micro = 32'h0200_0000 | EN;
        for (int c = 0; c < 6; c++) begin
            step();
            if (c == 1) i_cmd_from_micro = 32'h0100_0555 | EN;
            n_start += int'(o_start_conv);
            n_load  += int'(o_load);
        end
        i_cmd_from_micro = 32'h0100_0555;
        step();
        n_start += int'(o_start_conv);
        n_load  += int'(o_load);
        chk("held enable start count", 32'(n_start), 32'd1);
        chk("held enable load count", 32'(n_load), 32'd0);
        chk("held enable frame kept", 32'(o_frame_from_micro), 32'h007F_FFFF);
        i_cmd_from_micro = 32'h0100_0123 | EN;
        step();
        chk("load strobe before reset", 32'(o_load), 32'd1);
        chk("load frame before reset", 32'(o_frame_from_micro), 32'h0000_0123);
        reset = 1'b0;
        #1;
        chk("async reset load", 32'(o_load), 32'd0);
        chk("async reset frame", 32'(o_frame_from_micro), 32'd0);
        chk("async reset kernel", 32'(o_kernel_sel), 32'd0);
        chk("async reset data", o_data_to_micro, 32'd0);
        i_cmd_from_micro = 32'h0200_0000 | EN;
        repeat (2) step();
        chk("start in reset", 32'(o_start_conv), 32'd0);
        reset = 1'b1;
        n_start = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (c == 0) chk("start after release", 32'(o_start_conv), 32'd1);
            n_start += int'(o_start_conv);
        end
        chk("release with enable high once", 32'(n_start), 32'd1);
        i_cmd_from_micro = 32'h0;
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
